// File: rtl/sr_latch_writer.sv
// Write-side controller for an external gated SR latch: sequences set/reset and
// enable around a write request, then checks the synchronised readback.
module sr_latch_writer #(
  parameter int SETUP_CYCLES = 2,
  parameter int PULSE_CYCLES = 3,
  parameter int HOLD_CYCLES  = 1
) (
  input  logic clock,
  input  logic notreset,
  input  logic request,
  input  logic data,
  output logic latchEnable,
  output logic latchSet,
  output logic latchReset,
  input  logic latchOut,
  input  logic latchNotout,
  output logic busy,
  output logic done,
  output logic error,
  output logic storedValue
);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    PULSE,
    HOLD,
    SETTLE,
    CHECK
  } state_t;

  localparam logic [3:0] SETUP_LOAD  = (SETUP_CYCLES > 0) ? 4'(SETUP_CYCLES - 1) : '0;
  localparam logic [3:0] PULSE_LOAD  = (PULSE_CYCLES > 0) ? 4'(PULSE_CYCLES - 1) : '0;
  localparam logic [3:0] HOLD_LOAD   = (HOLD_CYCLES > 0) ? 4'(HOLD_CYCLES - 1) : '0;
  localparam logic [3:0] SETTLE_LOAD = 4'd1;

  state_t     state, state_next;
  logic [3:0] count, count_next;
  logic       data_q, data_load;
  logic [1:0] out_sync, notout_sync;
  logic       drive, pass;

  always_ff @(posedge clock or negedge notreset) begin
    if (!notreset) begin
      state       <= IDLE;
      count       <= '0;
      data_q      <= 1'b0;
      storedValue <= 1'b0;
      out_sync    <= '0;
      notout_sync <= '0;
    end else begin
      state       <= state_next;
      count       <= count_next;
      out_sync    <= {out_sync[0], latchOut};
      notout_sync <= {notout_sync[0], latchNotout};
      if (data_load) data_q <= data;
      if (state == CHECK && pass) storedValue <= data_q;
    end
  end

  always_comb begin
    state_next = state;
    count_next = count;
    data_load  = 1'b0;
    case (state)
      IDLE: begin
        count_next = '0;
        if (request) begin
          data_load = 1'b1;
          if (SETUP_CYCLES != 0) begin
            state_next = SETUP;
            count_next = SETUP_LOAD;
          end else begin
            state_next = PULSE;
            count_next = PULSE_LOAD;
          end
        end
      end
      SETUP: begin
        if (count == '0) begin
          state_next = PULSE;
          count_next = PULSE_LOAD;
        end else begin
          count_next = count - 4'd1;
        end
      end
      PULSE: begin
        if (count == '0) begin
          if (HOLD_CYCLES != 0) begin
            state_next = HOLD;
            count_next = HOLD_LOAD;
          end else begin
            state_next = SETTLE;
            count_next = SETTLE_LOAD;
          end
        end else begin
          count_next = count - 4'd1;
        end
      end
      HOLD: begin
        if (count == '0) begin
          state_next = SETTLE;
          count_next = SETTLE_LOAD;
        end else begin
          count_next = count - 4'd1;
        end
      end
      SETTLE: begin
        if (count == '0) begin
          state_next = CHECK;
          count_next = '0;
        end else begin
          count_next = count - 4'd1;
        end
      end
      CHECK: begin
        state_next = IDLE;
        count_next = '0;
      end
      default: begin
        state_next = IDLE;
        count_next = '0;
      end
    endcase
  end

  // Outputs decode straight from state so an async reset drops enable immediately.
  always_comb begin
    drive       = (state == SETUP) || (state == PULSE) || (state == HOLD);
    latchEnable = (state == PULSE);
    latchSet    = drive & data_q;
    latchReset  = drive & ~data_q;
    busy        = (state != IDLE);
    pass        = (out_sync[1] == data_q) && (notout_sync[1] == ~data_q);
    done        = (state == CHECK) && pass;
    error       = (state == CHECK) && !pass;
  end

endmodule

// File: tb/tb_sr_latch_writer.sv
// Scoreboard bench for sr_latch_writer driving behavioural gated SR latch models.
module tb_sr_latch_writer;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic notreset, request, data, stuck;
  logic en_a, set_a, rst_a, out_a, notout_a, busy_a, done_a, error_a, stored_a;
  logic request_b, data_b;
  logic en_b, set_b, rst_b, out_b, notout_b, busy_b, done_b, error_b, stored_b;
  logic q_a = 1'b0;
  logic q_b = 1'b0;

  sr_latch_writer u_dut (
    .clock(clock), .notreset(notreset), .request(request), .data(data),
    .latchEnable(en_a), .latchSet(set_a), .latchReset(rst_a),
    .latchOut(out_a), .latchNotout(notout_a),
    .busy(busy_a), .done(done_a), .error(error_a), .storedValue(stored_a)
  );

  sr_latch_writer #(.SETUP_CYCLES(0), .PULSE_CYCLES(3), .HOLD_CYCLES(0)) u_dut_b (
    .clock(clock), .notreset(notreset), .request(request_b), .data(data_b),
    .latchEnable(en_b), .latchSet(set_b), .latchReset(rst_b),
    .latchOut(out_b), .latchNotout(notout_b),
    .busy(busy_b), .done(done_b), .error(error_b), .storedValue(stored_b)
  );

  // Gated SR latches: transparent while enable is high.
  always @(en_a or set_a or rst_a) if (en_a) begin
    if (set_a) q_a = 1'b1;
    else if (rst_a) q_a = 1'b0;
  end
  always @(en_b or set_b or rst_b) if (en_b) begin
    if (set_b) q_b = 1'b1;
    else if (rst_b) q_b = 1'b0;
  end
  assign out_a    = stuck ? 1'b1 : q_a;
  assign notout_a = stuck ? 1'b1 : ~q_a;
  assign out_b    = q_b;
  assign notout_b = ~q_b;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic d;
    logic pass;
    int   acc;
  } txn_t;
  txn_t sbq[$];

  logic prev_busy = 1'b0, prev_req = 1'b0, prev_data = 1'b0;
  logic prev_set = 1'b0, prev_rst = 1'b0;
  logic exp_stored = 1'b0, chk_stored = 1'b0;
  int set_cnt = 0, rst_cnt = 0, en_cnt = 0, overlap_cnt = 0, change_cnt = 0;

  always @(negedge clock) begin
    if (!notreset) begin
      sbq.delete();
      exp_stored = 1'b0;
      chk_stored = 1'b0;
      prev_busy  = 1'b0;
      prev_req   = 1'b0;
      prev_set   = 1'b0;
      prev_rst   = 1'b0;
    end else begin
      if (set_a && rst_a) overlap_cnt++;
      if (en_a && (set_a != prev_set || rst_a != prev_rst)) change_cnt++;
      if (chk_stored) begin
        check_val("stored", 32'(stored_a), 32'(exp_stored));
        chk_stored = 1'b0;
      end
      if (!prev_busy) begin
        check_val("accept", 32'(busy_a), 32'(prev_req));
        if (busy_a) begin
          sbq.push_back('{d: prev_data, pass: !stuck, acc: cyc});
          set_cnt = 0;
          rst_cnt = 0;
          en_cnt  = 0;
        end
      end
      set_cnt += int'(set_a);
      rst_cnt += int'(rst_a);
      en_cnt  += int'(en_a);
      if (done_a || error_a) begin
        check_val("done_error_excl", 32'(done_a && error_a), 32'd0);
        if (sbq.size() == 0) begin
          check_val("sb_unexpected", 32'd1, 32'd0);
        end else begin
          txn_t t;
          t = sbq.pop_front();
          check_val("done", 32'(done_a), 32'(t.pass));
          check_val("error", 32'(error_a), 32'(!t.pass));
          check_val("latency", 32'(cyc - t.acc + 1), 32'd9);
          check_val("enable_cycles", 32'(en_cnt), 32'd3);
          check_val("set_cycles", 32'(set_cnt), t.d ? 32'd6 : 32'd0);
          check_val("reset_cycles", 32'(rst_cnt), t.d ? 32'd0 : 32'd6);
          if (t.pass) exp_stored = t.d;
          chk_stored = 1'b1;
        end
      end
      prev_busy = busy_a;
      prev_req  = request;
      prev_data = data;
      prev_set  = set_a;
      prev_rst  = rst_a;
    end
  end

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy_a && n < 40) begin
      @(posedge clock);
      #1;
      n++;
    end
    check_val(tag, 32'(busy_a), 32'd0);
    repeat (3) @(posedge clock);
    #1;
  endtask

  task automatic write_a(input logic d, input string tag);
    @(posedge clock);
    #1 request = 1'b1;
    data = d;
    @(posedge clock);
    #1 request = 1'b0;
    wait_idle(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    notreset = 1'b0; request = 1'b0; data = 1'b0; stuck = 1'b0;
    request_b = 1'b0; data_b = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check_val("reset_outputs",
              32'({en_a, set_a, rst_a, busy_a, done_a, error_a, stored_a}), 32'd0);
    @(posedge clock);
    #1 notreset = 1'b1;

    write_a(1'b1, "idle_set");
    check_val("latch_after_set", 32'(q_a), 32'd1);
    write_a(1'b0, "idle_reset");
    check_val("latch_after_reset", 32'(q_a), 32'd0);

    stuck = 1'b1;
    write_a(1'b1, "idle_stuck");
    stuck = 1'b0;
    check_val("stored_after_stuck", 32'(stored_a), 32'd0);

    // Async reset in the middle of the enable pulse.
    write_a(1'b1, "idle_set2");
    @(posedge clock);
    #1 request = 1'b1;
    data = 1'b0;
    @(posedge clock);
    #1 request = 1'b0;
    repeat (2) @(posedge clock);
    #2;
    check_val("pulse_before_reset", 32'(en_a), 32'd1);
    notreset = 1'b0;
    #1;
    check_val("reset_mid_pulse",
              32'({en_a, set_a, rst_a, busy_a, stored_a}), 32'd0);
    @(posedge clock);
    #1 notreset = 1'b1;
    repeat (2) @(posedge clock);

    for (int i = 0; i < 40; i++) begin
      @(posedge clock);
      #1 request = 1'b1;
      data = i[0];
    end
    @(posedge clock);
    #1 request = 1'b0;
    wait_idle("idle_spam");
    check_val("sb_drained", 32'(sbq.size()), 32'd0);
    check_val("set_reset_overlap", 32'(overlap_cnt), 32'd0);
    check_val("enable_while_changing", 32'(change_cnt), 32'd0);

    @(posedge clock);
    #1 request_b = 1'b1;
    data_b = 1'b1;
    @(posedge clock);
    #1 request_b = 1'b0;
    check_val("b_enable_rise", 32'(en_b), 32'd1);
    n = 1;
    while (!done_b && !error_b && n < 30) begin
      @(posedge clock);
      #1;
      n++;
    end
    check_val("b_latency", 32'(n), 32'd6);
    check_val("b_done", 32'({done_b, error_b}), 32'd2);
    @(posedge clock);
    #1;
    check_val("b_stored", 32'({stored_b, busy_b}), 32'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
